// File: rtl/mod_arith_seq_pkg.sv
// Shared opcodes, FSM encodings and width-generic modular helpers for mod_arith_seq.
// Helpers work on 64-bit words and are narrowed by callers, so any DATA_WIDTH <= 64 fits.
// Pure combinational functions with no flow control of their own.
package mod_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_EXP = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WORD_W = 64;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [2*WORD_W-1:0] dword_t;

  // Reduce a double-width value modulo m.
  function automatic word_t f_red(input dword_t v, input word_t m);
    return word_t'(v % dword_t'(m));
  endfunction

  // Modular add of two already-reduced operands; one carry bit avoids overflow.
  function automatic word_t f_add(input word_t a, input word_t b, input word_t m);
    logic [WORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return word_t'(s);
  endfunction

  // Modular subtract of two already-reduced operands; the wrap is undone by adding m.
  function automatic word_t f_sub(input word_t a, input word_t b, input word_t m);
    return (a >= b) ? (a - b) : (a - b + m);
  endfunction

endpackage

// File: rtl/mod_arith_seq_if.sv
// Request/response bundle for mod_arith_seq: valid/ready request and result channels.
// No latency of its own; carries the busy indicator alongside.
// Backpressure via in_ready (request side) and out_ready (result side).
interface mod_arith_if #(
  parameter int DATA_WIDTH = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] y;
  logic [EXP_WIDTH-1:0]  exp;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic                  busy;

  modport master (
    output in_valid, op, x, y, exp, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, busy
  );

  modport slave (
    input  in_valid, op, x, y, exp, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, busy
  );
endinterface

// File: rtl/mod_arith_seq_mul_red.sv
// Combinational modular multiply: p = (a * b) % MODULUS using a full double-width product.
// Zero latency.
// No flow control; purely combinational.
module mod_mul_red
  import mod_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MODULUS    = 17
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] p
);
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
  assign p    = DATA_WIDTH'(f_red(dword_t'(prod), word_t'(MODULUS)));
endmodule

// File: rtl/mod_arith_seq.sv
// Handshaked modular ALU (ADD/SUB/MUL/EXP mod MODULUS) with a tag carried per op.
// ADD/SUB/MUL: result registered at accept; EXP: one exponent bit per cycle, MSB first.
// Result held until out_ready; a new op may be accepted in the same cycle the result is taken.
module mod_arith_seq
  import mod_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MODULUS    = 17,
  parameter int EXP_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4
) (
  input logic        clk,
  input logic        rst,
  mod_arith_if.slave bus
);
  localparam int CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  typedef logic [DATA_WIDTH-1:0] data_t;

  logic [1:0]           state;
  data_t                base, acc, res;
  data_t                x_red, y_red, alu, sq, sq_mul, step, mul0_a, mul0_b;
  logic [EXP_WIDTH-1:0] e;
  logic [CNT_W-1:0]     cnt;
  logic [TAG_WIDTH-1:0] tag;
  logic                 valid;
  logic                 accept;

  assign x_red = data_t'(f_red(dword_t'(bus.x), word_t'(MODULUS)));
  assign y_red = data_t'(f_red(dword_t'(bus.y), word_t'(MODULUS)));

  // Taking the held result frees the slot, so a new request can ride the same edge.
  assign bus.in_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  // Multiplier 0 squares the accumulator during EXP and serves MUL otherwise.
  assign mul0_a = (state == ST_EXP) ? acc : x_red;
  assign mul0_b = (state == ST_EXP) ? acc : y_red;

  mod_mul_red #(.DATA_WIDTH(DATA_WIDTH), .MODULUS(MODULUS)) u_mul0 (
    .a(mul0_a), .b(mul0_b), .p(sq)
  );

  mod_mul_red #(.DATA_WIDTH(DATA_WIDTH), .MODULUS(MODULUS)) u_mul1 (
    .a(sq), .b(base), .p(sq_mul)
  );

  assign step = e[cnt] ? sq_mul : sq;

  // Single-cycle ops, evaluated on the reduced operands at the accept edge.
  always_comb begin
    alu = '0;
    case (bus.op)
      OP_ADD:  alu = data_t'(f_add(word_t'(x_red), word_t'(y_red), word_t'(MODULUS)));
      OP_SUB:  alu = data_t'(f_sub(word_t'(x_red), word_t'(y_red), word_t'(MODULUS)));
      OP_MUL:  alu = sq;
      default: alu = '0;
    endcase
  end

  // FSM plus operand, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      res   <= '0;
      tag   <= '0;
      base  <= '0;
      acc   <= '0;
      e     <= '0;
      cnt   <= '0;
    end else if (accept) begin
      tag <= bus.tag_in;
      if (bus.op == OP_EXP) begin
        base  <= x_red;
        acc   <= data_t'(1);
        e     <= bus.exp;
        cnt   <= CNT_W'(EXP_WIDTH - 1);
        valid <= 1'b0;
        state <= ST_EXP;
      end else begin
        res   <= alu;
        valid <= 1'b1;
        state <= ST_DONE;
      end
    end else if (state == ST_EXP) begin
      acc <= step;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        res   <= step;
        valid <= 1'b1;
        state <= ST_DONE;
      end
    end else if ((state == ST_DONE) && bus.out_ready) begin
      valid <= 1'b0;
      state <= ST_IDLE;
    end
  end

  assign bus.out_valid = valid;
  assign bus.result    = res;
  assign bus.tag_out   = tag;
  assign bus.busy      = (state == ST_EXP);
endmodule

// File: tb/tb_mod_arith_seq.sv
// Directed self-checking bench for mod_arith_seq (DATA_WIDTH=16, MODULUS=17, EXP_WIDTH=8).
// Inputs driven 1 time unit after the rising edge, outputs sampled at that same offset.
// Each scenario task carries its own expected values.
module tb_mod_arith_seq;
  import mod_arith_pkg::*;

  localparam int DW = 16;
  localparam int M  = 17;
  localparam int EW = 8;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mod_arith_if #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .TAG_WIDTH(TW)) bus ();

  mod_arith_seq #(.DATA_WIDTH(DW), .MODULUS(M), .EXP_WIDTH(EW), .TAG_WIDTH(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [EW-1:0] e, input logic [TW-1:0] t);
    bus.op       = op;
    bus.x        = x;
    bus.y        = y;
    bus.exp      = e;
    bus.tag_in   = t;
    bus.in_valid = 1'b1;
    #1;
  endtask

  // Present a request, wait (bounded) for in_ready, and let it be accepted on the next edge.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [EW-1:0] e, input logic [TW-1:0] t);
    int n;
    drive_op(op, x, y, e, t);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts cycles from that edge until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = OP_ADD;
    bus.x         = '0;
    bus.y         = '0;
    bus.exp       = '0;
    bus.tag_in    = '0;
    tick(); tick(); tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b required 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
    checks++;
    if (bus.result !== 16'd0) begin failures++; $display("FAIL reset_result: got %0d required 0", bus.result); end
    checks++;
    if (bus.tag_out !== 4'd0) begin failures++; $display("FAIL reset_tag_out: got %0d required 0", bus.tag_out); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %0b required 1", bus.in_ready); end
  endtask

  // Single-cycle ops: {op, x, y, tag, expected}.
  task automatic test_single_cycle();
    logic [1:0]    ops [5] = '{OP_ADD, OP_SUB, OP_MUL, OP_ADD, OP_ADD};
    logic [DW-1:0] xs  [5] = '{16'd16, 16'd3, 16'd16, 16'd20, 16'hFFFF};
    logic [DW-1:0] ys  [5] = '{16'd5,  16'd5, 16'd16, 16'd0,  16'hFFFF};
    logic [TW-1:0] tgs [5] = '{4'd3, 4'd5, 4'd7, 4'd10, 4'd15};
    logic [DW-1:0] exs [5] = '{16'd4,  16'd15, 16'd1, 16'd3, 16'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], xs[i], ys[i], '0, tgs[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL op%0d_latency: got %0d required 1", i, lat); end
      checks++;
      if (bus.result !== exs[i]) begin failures++; $display("FAIL op%0d_result: got %0d required %0d", i, bus.result, exs[i]); end
      checks++;
      if (bus.tag_out !== tgs[i]) begin failures++; $display("FAIL op%0d_tag: got %0d required %0d", i, bus.tag_out, tgs[i]); end
      tick();
    end
  endtask

  // EXP cases: {x, exp, expected}; latency 9 and busy for 8 cycles each.
  task automatic test_exp();
    logic [DW-1:0] xs  [5] = '{16'd3,  16'd2,   16'd0, 16'd17, 16'd5};
    logic [EW-1:0] es  [5] = '{8'd16,  8'd255,  8'd0,  8'd5,   8'd1};
    logic [DW-1:0] exs [5] = '{16'd1,  16'd9,   16'd1, 16'd0,  16'd5};
    int lat;
    int busy_cnt;
    for (int i = 0; i < 5; i++) begin
      issue(OP_EXP, xs[i], 16'd0, es[i], TW'(i + 1));
      lat      = 1;
      busy_cnt = 0;
      while (lat < 40) begin
        if (bus.busy) busy_cnt++;
        if (bus.out_valid) break;
        tick();
        lat++;
      end
      checks++;
      if (lat !== 9) begin failures++; $display("FAIL exp%0d_latency: got %0d required 9", i, lat); end
      checks++;
      if (busy_cnt !== 8) begin failures++; $display("FAIL exp%0d_busy_cycles: got %0d required 8", i, busy_cnt); end
      checks++;
      if (bus.result !== exs[i]) begin failures++; $display("FAIL exp%0d_result: got %0d required %0d", i, bus.result, exs[i]); end
      checks++;
      if (bus.tag_out !== TW'(i + 1)) begin failures++; $display("FAIL exp%0d_tag: got %0d required %0d", i, bus.tag_out, i + 1); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    issue(OP_ADD, 16'd7, 16'd8, '0, 4'd9);
    wait_valid(lat);
    // A pending request must not be accepted while the result is stalled.
    drive_op(OP_MUL, 16'd4, 16'd5, '0, 4'd2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall%0d_out_valid: got %0b required 1", i, bus.out_valid); end
      checks++;
      if (bus.result !== 16'd15) begin failures++; $display("FAIL stall%0d_result: got %0d required 15", i, bus.result); end
      checks++;
      if (bus.tag_out !== 4'd9) begin failures++; $display("FAIL stall%0d_tag: got %0d required 9", i, bus.tag_out); end
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d_in_ready: got %0b required 0", i, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %0b required 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL swap_out_valid: got %0b required 1", bus.out_valid); end
    checks++;
    if (bus.result !== 16'd3) begin failures++; $display("FAIL swap_result: got %0d required 3", bus.result); end
    checks++;
    if (bus.tag_out !== 4'd2) begin failures++; $display("FAIL swap_tag: got %0d required 2", bus.tag_out); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid: got %0b required 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive_op(OP_ADD, 16'd2, 16'd3, '0, 4'd1);
    tick();
    drive_op(OP_SUB, 16'd2, 16'd3, '0, 4'd2);
    checks++;
    if (bus.result !== 16'd5 || bus.tag_out !== 4'd1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got v=%0b r=%0d t=%0d required v=1 r=5 t=1", bus.out_valid, bus.result, bus.tag_out);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.result !== 16'd16 || bus.tag_out !== 4'd2 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: got v=%0b r=%0d t=%0d required v=1 r=16 t=2", bus.out_valid, bus.result, bus.tag_out);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %0b required 0", bus.out_valid); end
  endtask

  task automatic test_rst_abort();
    int lat;
    issue(OP_EXP, 16'd3, 16'd0, 8'd200, 4'd4);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid: got %0b required 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b required 0", bus.busy); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready: got %0b required 1", bus.in_ready); end
    issue(OP_ADD, 16'd1, 16'd1, '0, 4'd6);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL post_abort_latency: got %0d required 1", lat); end
    checks++;
    if (bus.result !== 16'd2) begin failures++; $display("FAIL post_abort_result: got %0d required 2", bus.result); end
    checks++;
    if (bus.tag_out !== 4'd6) begin failures++; $display("FAIL post_abort_tag: got %0d required 6", bus.tag_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_exp();
    test_backpressure();
    test_back_to_back();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
